// File: rtl/bin_to_bcd8.sv
// rtl/bin_to_bcd8.sv - sequential double-dabble binary to 8-digit packed BCD converter
// Optional leading-zero blanking: define BIN_TO_BCD8_LZB_EN.
module bin_to_bcd8 #(
    parameter int         BIN_W      = 27,
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [31:0]      bcd_out
);
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BIN_W-1:0]   r_shift;
    logic [31:0]        r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_flag;
    logic [31:0]        r_bcd;
    logic               r_ovf;
    logic               r_done;
    logic [31:0]        w_adj;
    logic [31:0]        w_final;
    logic               w_in_ovf;
    logic               w_unused_msb;

    assign w_in_ovf     = {{(32-BIN_W){1'b0}}, bin_in} > 32'd99_999_999;
    assign w_unused_msb = w_adj[31];

    // All eight digits are corrected in parallel before the shift.
    always_comb begin
        w_adj = r_acc;
        for (int k = 0; k < 8; k++) begin
            if (r_acc[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
            end
        end
    end

`ifdef BIN_TO_BCD8_LZB_EN
    logic w_lead;
    always_comb begin
        w_final = r_acc;
        w_lead  = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            if (w_lead && (r_acc[4*k +: 4] == 4'd0)) begin
                w_final[4*k +: 4] = BLANK_CODE;
            end else begin
                w_lead = 1'b0;
            end
        end
    end
`else
    logic [3:0] w_unused_blank;
    assign w_unused_blank = BLANK_CODE;
    assign w_final        = r_acc;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CONV;
            S_CONV:  if (r_cnt == CNT_W'(BIN_W - 1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf_flag <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift    <= bin_in;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_ovf_flag <= w_in_ovf;
                    end
                end
                S_CONV: begin
                    r_acc   <= {w_adj[30:0], r_shift[BIN_W-1]};
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_bcd  <= r_ovf_flag ? 32'h9999_9999 : w_final;
                    r_ovf  <= r_ovf_flag;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign ovf     = r_ovf;
    assign bcd_out = r_bcd;
endmodule

// File: tb/tb_bin_to_bcd8.sv
// tb/tb_bin_to_bcd8.sv - randomized self-checking bench for bin_to_bcd8 against a behavioural model
module tb_bin_to_bcd8;
    localparam int BIN_W = 27;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;
    logic             busy, done, ovf;
    logic [31:0]      bcd_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bin_to_bcd8 #(.BIN_W(BIN_W), .BLANK_CODE(4'hF)) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .bcd_out (bcd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_bcd(input longint v);
        logic [31:0] r;
        longint      x;
        if (v > 99_999_999) return 32'h9999_9999;
        r = '0;
        x = v;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef BIN_TO_BCD8_LZB_EN
        for (int k = 7; k >= 1; k--) begin
            if (r[4*k +: 4] != 4'd0) break;
            r[4*k +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    function automatic logic [31:0] pick(input logic [31:0] raw, input logic [31:0] lzb);
`ifdef BIN_TO_BCD8_LZB_EN
        return lzb;
`else
        return raw;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a conversion accepted in idle produces its result BIN_W+1 edges later.
    int          m_rem;
    logic [31:0] m_bcd, m_pend;
    logic        m_ovf, m_povf, m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_bcd  <= '0;
            m_ovf  <= 1'b0;
            m_done <= 1'b0;
            m_pend <= '0;
            m_povf <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_bcd  <= m_pend;
                    m_ovf  <= m_povf;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                m_rem  <= BIN_W + 1;
                m_pend <= ref_bcd(longint'(bin_in));
                m_povf <= (longint'(bin_in) > 99_999_999);
            end
        end
    end

    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
        check("bcd_out", bcd_out, m_bcd);
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, expected pulse", name, n);
        end
    endtask

    task automatic do_conv(input string name, input logic [BIN_W-1:0] v,
                           input logic [31:0] exp_bcd, input logic exp_ovf);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
        wait_done(name);
        check({name, "_bcd"}, bcd_out, exp_bcd);
        check({name, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    endtask

    initial begin
        logic [BIN_W-1:0] v;
        int               t_last;
        int               n_done;

        check("pin_12345678", ref_bcd(12_345_678), 32'h1234_5678);
        check("pin_zero", ref_bcd(0), pick(32'h0000_0000, 32'hFFFF_FFF0));
        check("pin_305", ref_bcd(305), pick(32'h0000_0305, 32'hFFFF_F305));
        check("pin_1e7", ref_bcd(10_000_000), 32'h1000_0000);
        check("pin_ovf", ref_bcd(100_000_000), 32'h9999_9999);

        repeat (3) @(negedge clk);
        check("rst_bcd", bcd_out, 32'h0);
        check("rst_flags", {29'd0, busy, done, ovf}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_conv("nominal", 27'd12_345_678, 32'h1234_5678, 1'b0);
        do_conv("zero", 27'd0, pick(32'h0, 32'hFFFF_FFF0), 1'b0);
        do_conv("max_ok", 27'd99_999_999, 32'h9999_9999, 1'b0);
        do_conv("ovf_min", 27'd100_000_000, 32'h9999_9999, 1'b1);
        do_conv("ovf_max", 27'h7FF_FFFF, 32'h9999_9999, 1'b1);
        do_conv("v305", 27'd305, pick(32'h0000_0305, 32'hFFFF_F305), 1'b0);
        do_conv("v1e7", 27'd10_000_000, 32'h1000_0000, 1'b0);

        // start pulsed mid-conversion must be ignored
        @(negedge clk);
        start = 1'b1; bin_in = 27'd12_345_678;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; bin_in = 27'd42;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        check("busy_start_bcd", bcd_out, 32'h1234_5678);

        for (int i = 0; i < 20; i++) begin
            case (i % 4)
                0: v = BIN_W'($urandom_range(0, 999));
                1: v = BIN_W'($urandom_range(99_999_990, 100_000_010));
                default: v = BIN_W'($urandom);
            endcase
            do_conv("random", v, ref_bcd(longint'(v)), (longint'(v) > 99_999_999));
        end

        // start held high: back-to-back conversions 29 cycles apart
        @(negedge clk);
        start  = 1'b1;
        t_last = -1;
        n_done = 0;
        for (int c = 0; c < 130; c++) begin
            bin_in = BIN_W'($urandom);
            @(negedge clk);
            if (done) begin
                if (t_last >= 0) check("done_spacing", 32'(cyc - t_last), 32'd29);
                t_last = cyc;
                n_done++;
            end
        end
        start = 1'b0;
        check("held_done_count", 32'(n_done), 32'd4);
        repeat (35) @(negedge clk);

        // reset mid-conversion aborts it
        @(negedge clk);
        start = 1'b1; bin_in = 27'd87_654_321;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_bcd", bcd_out, 32'h0);
        check("midrst_flags", {29'd0, busy, done, ovf}, 32'h0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("midrst_no_done", {31'd0, done}, 32'd0);
        do_conv("after_rst", 27'd7, pick(32'h0000_0007, 32'hFFFF_FFF7), 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
